uart_bus_arbiter: RTL

- Owns the single register port of the `uart` core and shares it between two requesters, m0 and m1, using round-robin arbitration.
- After reset it performs one configuration write to the control register before granting any requester.
- Each granted request becomes exactly one one-cycle `scisel` access, followed by a registered acknowledge and read data.
- Sits between the `uart` core and the two client controllers (e.g. a host-side bridge and a loopback/echo engine). It also steers `sciirq` to its configured owner.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/uart_bus_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart register-port arbiter and its clients.
// Holds the arbiter state encoding, uart register addresses, the
// direction encoding and the TDRE bit position of the status register.
package uart_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    ACC  = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  localparam logic RW_WR = 1'b1;
  localparam logic RW_RD = 1'b0;

  localparam int TDRE_BIT = 7;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant.
// Ports:
//   req_i       [1:0] request vector, bit n = requester n
//   rr_ptr_i          requester favoured when both request
//   gnt_valid_o       at least one request present
//   gnt_id_o          index of the granted requester
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  // Grant selection: a lone requester always wins, a tie goes to rr_ptr_i
  always_comb begin
    gnt_valid_o = |req_i;
    if (req_i == 2'b11) begin
      gnt_id_o = rr_ptr_i;
    end else if (req_i[1]) begin
      gnt_id_o = 1'b1;
    end else begin
      gnt_id_o = 1'b0;
    end
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares the single uart register port between requesters m0 and m1.
// After reset one control-register write (INIT_CTRL) is issued, then
// requests are granted round-robin; each grant becomes one scisel cycle
// followed by a one-cycle ack carrying read data. sciirq is re-timed by
// one flop and routed to IRQ_OWNER.
// Ports:
//   clk, rstb                      clock, synchronous active-low reset
//   m{0,1}_req/rw/addr/wdata       requester side inputs
//   m{0,1}_ack/rdata               completion pulse and read data
//   m{0,1}_irq                     routed uart interrupt
//   scisel/rw/addr/dbus_o/dbus_oe  uart register port (all registered)
//   dbus_i, sciirq                 uart data bus sample and interrupt
//   busy                           high whenever the arbiter is not idle
module uart_bus_arbiter
  import uart_pkg::*;
#(
  parameter logic [7:0] INIT_CTRL = 8'h40,
  parameter int         IRQ_OWNER = 0
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       m0_req,
  input  logic       m0_rw,
  input  logic [1:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic       m0_ack,
  output logic [7:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_rw,
  input  logic [1:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m1_ack,
  output logic [7:0] m1_rdata,
  output logic       m0_irq,
  output logic       m1_irq,
  output logic       scisel,
  output logic       rw,
  output logic [1:0] addr,
  output logic [7:0] dbus_o,
  output logic       dbus_oe,
  input  logic [7:0] dbus_i,
  input  logic       sciirq,
  output logic       busy
);

  state_e     state_q;
  logic       init_done_q;
  logic       rr_ptr_q;
  logic       gnt_id_q;
  logic       lat_rw_q;
  logic [7:0] rdata_q;
  logic       scisel_q;
  logic       rw_q;
  logic [1:0] addr_q;
  logic [7:0] dbus_o_q;
  logic       dbus_oe_q;
  logic       busy_q;
  logic       m0_ack_q;
  logic       m1_ack_q;
  logic [7:0] m0_rdata_q;
  logic [7:0] m1_rdata_q;
  logic       irq_q;

  logic       gnt_valid_s;
  logic       gnt_id_s;
  logic       sel_rw_s;
  logic [1:0] sel_addr_s;
  logic [7:0] sel_wdata_s;
  logic [7:0] ack_rdata_s;

  rr_arb2 u_rr_arb2 (
    .req_i       ({m1_req, m0_req}),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_valid_o (gnt_valid_s),
    .gnt_id_o    (gnt_id_s)
  );

  // Request fields of whichever requester the arbiter would grant
  always_comb begin
    if (gnt_id_s) begin
      sel_rw_s    = m1_rw;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_rw_s    = m0_rw;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
  end

  // A write ack returns the last captured read value, a read ack the fresh bus sample
  assign ack_rdata_s = (lat_rw_q == RW_WR) ? rdata_q : dbus_i;

  // Arbiter FSM with all port outputs registered
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= INIT;
      init_done_q <= 1'b0;
      rr_ptr_q    <= 1'b0;
      gnt_id_q    <= 1'b0;
      lat_rw_q    <= 1'b0;
      rdata_q     <= 8'h00;
      scisel_q    <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= 2'b00;
      dbus_o_q    <= 8'h00;
      dbus_oe_q   <= 1'b0;
      busy_q      <= 1'b1;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= 8'h00;
      m1_rdata_q  <= 8'h00;
      irq_q       <= 1'b0;
    end else begin
      // Bus and ack outputs are single-cycle unless a branch below drives them
      scisel_q   <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= 2'b00;
      dbus_o_q   <= 8'h00;
      dbus_oe_q  <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 8'h00;
      m1_rdata_q <= 8'h00;
      irq_q      <= (state_q == INIT) ? 1'b0 : sciirq;

      case (state_q)
        INIT: begin
          // First edge out of reset launches the control write; the next one leaves INIT
          if (!init_done_q) begin
            scisel_q    <= 1'b1;
            rw_q        <= RW_WR;
            addr_q      <= ADDR_CTRL;
            dbus_o_q    <= INIT_CTRL;
            dbus_oe_q   <= 1'b1;
            init_done_q <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (gnt_valid_s) begin
            gnt_id_q  <= gnt_id_s;
            lat_rw_q  <= sel_rw_s;
            scisel_q  <= 1'b1;
            rw_q      <= sel_rw_s;
            addr_q    <= sel_addr_s;
            dbus_o_q  <= (sel_rw_s == RW_WR) ? sel_wdata_s : 8'h00;
            dbus_oe_q <= (sel_rw_s == RW_WR);
            busy_q    <= 1'b1;
            state_q   <= ACC;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ACC: begin
          if (lat_rw_q == RW_RD) begin
            rdata_q <= dbus_i;
          end
          if (gnt_id_q) begin
            m1_ack_q   <= 1'b1;
            m1_rdata_q <= ack_rdata_s;
          end else begin
            m0_ack_q   <= 1'b1;
            m0_rdata_q <= ack_rdata_s;
          end
          busy_q  <= 1'b1;
          state_q <= ACK;
        end
        ACK: begin
          rr_ptr_q <= ~gnt_id_q;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q     <= INIT;
          init_done_q <= 1'b0;
          busy_q      <= 1'b1;
        end
      endcase
    end
  end

  assign scisel   = scisel_q;
  assign rw       = rw_q;
  assign addr     = addr_q;
  assign dbus_o   = dbus_o_q;
  assign dbus_oe  = dbus_oe_q;
  assign busy     = busy_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_irq   = (IRQ_OWNER == 32'sd0) ? irq_q : 1'b0;
  assign m1_irq   = (IRQ_OWNER != 32'sd0) ? irq_q : 1'b0;

endmodule
